// File: rtl/tone_event_pkg.sv
// Shared types and width helpers for the tone event detector.
package tone_event_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        ACTIVE    = 2'd2,
        RELEASING = 2'd3
    } band_state_t;

    // Bits needed to hold 0..max_val, never less than 1.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to index n items, never less than 1.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tone_event_detector_band_tracker.sv
// One frequency band: hit/miss evaluation, onset debounce and release hysteresis.
module band_tracker
    import tone_event_pkg::*;
#(
    parameter int BIN_W      = 10,
    parameter int MAG_W      = 33,
    parameter int ON_FRAMES  = 3,
    parameter int OFF_FRAMES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             frame_valid,
    input  logic [BIN_W-1:0] peak_bin,
    input  logic [MAG_W-1:0] peak_mag,
    input  logic [BIN_W-1:0] lo,
    input  logic [BIN_W-1:0] hi,
    input  logic [MAG_W-1:0] thresh,
    output logic             active,
    output logic             onset,
    output logic             offset,
    output logic             active_nxt,
    output logic             onset_nxt,
    output band_state_t      state
);

    localparam int ON_W  = cnt_width(ON_FRAMES);
    localparam int OFF_W = cnt_width(OFF_FRAMES);

    band_state_t      state_nxt;
    logic [ON_W-1:0]  on_cnt, on_cnt_nxt;
    logic [OFF_W-1:0] off_cnt, off_cnt_nxt;
    logic             hit, miss;
    logic             offset_nxt;

    // An inverted range (lo > hi) can never satisfy both bounds, so it never hits.
    assign hit  = frame_valid && (peak_bin >= lo) && (peak_bin <= hi) && (peak_mag >= thresh);
    assign miss = frame_valid && !hit;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state   <= IDLE;
            on_cnt  <= '0;
            off_cnt <= '0;
            active  <= 1'b0;
            onset   <= 1'b0;
            offset  <= 1'b0;
        end else begin
            state   <= state_nxt;
            on_cnt  <= on_cnt_nxt;
            off_cnt <= off_cnt_nxt;
            active  <= active_nxt;
            onset   <= onset_nxt;
            offset  <= offset_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        on_cnt_nxt  = on_cnt;
        off_cnt_nxt = off_cnt;
        case (state)
            IDLE: begin
                if (hit) begin
                    if (ON_FRAMES == 1) begin
                        state_nxt = ACTIVE;
                    end else begin
                        state_nxt  = ARMING;
                        on_cnt_nxt = ON_W'(1);
                    end
                end
            end
            ARMING: begin
                if (hit) begin
                    if ((on_cnt + ON_W'(1)) == ON_W'(ON_FRAMES)) begin
                        state_nxt  = ACTIVE;
                        on_cnt_nxt = '0;
                    end else begin
                        on_cnt_nxt = on_cnt + ON_W'(1);
                    end
                end else if (miss) begin
                    state_nxt  = IDLE;
                    on_cnt_nxt = '0;
                end
            end
            ACTIVE: begin
                if (miss) begin
                    if (OFF_FRAMES == 1) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = RELEASING;
                        off_cnt_nxt = OFF_W'(1);
                    end
                end
            end
            RELEASING: begin
                if (hit) begin
                    state_nxt   = ACTIVE;
                    off_cnt_nxt = '0;
                end else if (miss) begin
                    if ((off_cnt + OFF_W'(1)) == OFF_W'(OFF_FRAMES)) begin
                        state_nxt   = IDLE;
                        off_cnt_nxt = '0;
                    end else begin
                        off_cnt_nxt = off_cnt + OFF_W'(1);
                    end
                end
            end
            default: begin
                state_nxt   = IDLE;
                on_cnt_nxt  = '0;
                off_cnt_nxt = '0;
            end
        endcase
    end

    // RELEASING -> ACTIVE is a recovery, not a new onset.
    always_comb begin
        active_nxt = (state_nxt == ACTIVE) || (state_nxt == RELEASING);
        onset_nxt  = (state_nxt == ACTIVE) && ((state == IDLE) || (state == ARMING));
        offset_nxt = (state_nxt == IDLE) && ((state == ACTIVE) || (state == RELEASING));
    end

endmodule

// File: rtl/tone_event_detector.sv
// Multi-band tone event detector: per-band trackers plus fire, lowest-band index and onset count.
module tone_event_detector
    import tone_event_pkg::*;
#(
    parameter int BIN_W      = 10,
    parameter int MAG_W      = 33,
    parameter int N_BANDS    = 4,
    parameter int ON_FRAMES  = 3,
    parameter int OFF_FRAMES = 5,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         frame_valid,
    input  logic [BIN_W-1:0]             peak_bin,
    input  logic [MAG_W-1:0]             peak_mag,
    input  logic [N_BANDS*BIN_W-1:0]     band_lo,
    input  logic [N_BANDS*BIN_W-1:0]     band_hi,
    input  logic [N_BANDS*MAG_W-1:0]     band_thresh,
    output logic [N_BANDS-1:0]           band_active,
    output logic                         fire,
    output logic [N_BANDS-1:0]           onset_pulse,
    output logic [N_BANDS-1:0]           offset_pulse,
    output logic [idx_width(N_BANDS)-1:0] event_band,
    output logic [CNT_W-1:0]             event_count,
    output logic [2*N_BANDS-1:0]         band_state
);

    // frame_valid is a one-cycle strobe with no back-pressure: every strobe is
    // consumed on the edge that samples it, so frames may arrive every cycle.

    localparam int EB_W  = idx_width(N_BANDS);
    localparam int PC_W  = cnt_width(N_BANDS);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N_BANDS-1:0] active_nxt;
    logic [N_BANDS-1:0] onset_nxt;
    logic [PC_W-1:0]    onset_cnt;
    logic [SUM_W-1:0]   sum;
    logic [CNT_W-1:0]   count_nxt;
    logic [EB_W-1:0]    event_band_nxt;

    for (genvar i = 0; i < N_BANDS; i++) begin : g_band
        band_state_t trk_state;

        band_tracker #(
            .BIN_W      (BIN_W),
            .MAG_W      (MAG_W),
            .ON_FRAMES  (ON_FRAMES),
            .OFF_FRAMES (OFF_FRAMES)
        ) u_band (
            .clk         (clk),
            .reset       (reset),
            .clear       (clear),
            .frame_valid (frame_valid),
            .peak_bin    (peak_bin),
            .peak_mag    (peak_mag),
            .lo          (band_lo[i*BIN_W +: BIN_W]),
            .hi          (band_hi[i*BIN_W +: BIN_W]),
            .thresh      (band_thresh[i*MAG_W +: MAG_W]),
            .active      (band_active[i]),
            .onset       (onset_pulse[i]),
            .offset      (offset_pulse[i]),
            .active_nxt  (active_nxt[i]),
            .onset_nxt   (onset_nxt[i]),
            .state       (trk_state)
        );

        assign band_state[2*i +: 2] = trk_state;
    end

    always_comb begin
        onset_cnt = '0;
        for (int i = 0; i < N_BANDS; i++) begin
            onset_cnt = onset_cnt + PC_W'(onset_nxt[i]);
        end
    end

    always_comb begin
        sum = SUM_W'(event_count) + SUM_W'(onset_cnt);
        if (sum > SUM_W'(CNT_MAX)) begin
            count_nxt = CNT_MAX;
        end else begin
            count_nxt = sum[CNT_W-1:0];
        end
    end

    // Scan from the top down so the lowest active index wins.
    always_comb begin
        event_band_nxt = '0;
        for (int i = N_BANDS - 1; i >= 0; i--) begin
            if (active_nxt[i]) begin
                event_band_nxt = EB_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            fire        <= 1'b0;
            event_band  <= '0;
            event_count <= '0;
        end else begin
            fire        <= |active_nxt;
            event_band  <= event_band_nxt;
            event_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_tone_event_detector.sv
// Self-checking bench for tone_event_detector: hand-derived expectations through a scoreboard queue.
module tb_tone_event_detector;
    import tone_event_pkg::*;

    typedef struct packed {
        logic [3:0]  act;
        logic [3:0]  on;
        logic [3:0]  off;
        logic        fire;
        logic [1:0]  eb;
        logic [15:0] cnt;
    } obs_t;

    typedef struct packed {
        logic        clr;
        logic        fv;
        logic [9:0]  bin;
        logic [32:0] mag;
        logic [3:0]  act;
        logic [3:0]  on;
        logic [3:0]  off;
        logic [15:0] cnt;
    } step_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic frame_valid = 1'b0;
    logic [9:0]  peak_bin = '0;
    logic [32:0] peak_mag = '0;
    logic [9:0]  lo [4];
    logic [9:0]  hi [4];
    logic [32:0] th [4];
    logic [39:0]  band_lo, band_hi;
    logic [131:0] band_thresh;

    logic [3:0]  act_a, on_a, off_a, act_b, on_b, off_b;
    logic        fire_a, fire_b;
    logic [1:0]  eb_a, eb_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;
    logic [7:0]  st_a, st_b;

    logic [30:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    assign band_lo     = {lo[3], lo[2], lo[1], lo[0]};
    assign band_hi     = {hi[3], hi[2], hi[1], hi[0]};
    assign band_thresh = {th[3], th[2], th[1], th[0]};

    always #5 clk = ~clk;

    tone_event_detector #(
        .BIN_W(10), .MAG_W(33), .N_BANDS(4), .ON_FRAMES(3), .OFF_FRAMES(5), .CNT_W(16)
    ) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .frame_valid(frame_valid),
        .peak_bin(peak_bin), .peak_mag(peak_mag),
        .band_lo(band_lo), .band_hi(band_hi), .band_thresh(band_thresh),
        .band_active(act_a), .fire(fire_a), .onset_pulse(on_a), .offset_pulse(off_a),
        .event_band(eb_a), .event_count(cnt_a), .band_state(st_a)
    );

    tone_event_detector #(
        .BIN_W(10), .MAG_W(33), .N_BANDS(4), .ON_FRAMES(1), .OFF_FRAMES(1), .CNT_W(2)
    ) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .frame_valid(frame_valid),
        .peak_bin(peak_bin), .peak_mag(peak_mag),
        .band_lo(band_lo), .band_hi(band_hi), .band_thresh(band_thresh),
        .band_active(act_b), .fire(fire_b), .onset_pulse(on_b), .offset_pulse(off_b),
        .event_band(eb_b), .event_count(cnt_b), .band_state(st_b)
    );

    function automatic step_t st(input logic clr, input logic fv, input logic [9:0] bin,
                                 input logic [32:0] mag, input logic [3:0] act,
                                 input logic [3:0] on, input logic [3:0] off,
                                 input logic [15:0] cnt);
        return '{clr: clr, fv: fv, bin: bin, mag: mag, act: act, on: on, off: off, cnt: cnt};
    endfunction

    // Expected outputs from a step: fire is any active band, event_band the lowest one.
    function automatic obs_t expect_of(input step_t s);
        obs_t e;
        e.act  = s.act;
        e.on   = s.on;
        e.off  = s.off;
        e.fire = |s.act;
        e.eb   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (s.act[i]) e.eb = 2'(i);
        end
        e.cnt = s.cnt;
        return e;
    endfunction

    function automatic obs_t obs_a();
        return '{act: act_a, on: on_a, off: off_a, fire: fire_a, eb: eb_a, cnt: cnt_a};
    endfunction

    function automatic obs_t obs_b();
        return '{act: act_b, on: on_b, off: off_b, fire: fire_b, eb: eb_b, cnt: {14'd0, cnt_b}};
    endfunction

    task automatic drive(input step_t s);
        clear       = s.clr;
        frame_valid = s.fv;
        peak_bin    = s.bin;
        peak_mag    = s.mag;
        @(posedge clk);
        #1;
        clear       = 1'b0;
        frame_valid = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(st(1'b0, 1'b1, 10'd15, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd0));
            got = obs_a();
            vectors++;
            if (got !== obs_t'(0)) begin
                miscompares++;
                $display("FAIL reset_a cycle %0d: got %h expected 0", i, got);
            end
            got = obs_b();
            vectors++;
            if (got !== obs_t'(0) || st_a !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_b cycle %0d: got %h state %h expected 0", i, got, st_a);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_onset();
        step_t s[$];
        obs_t got, e;
        s.push_back(st(1, 0, 10'd0,  33'h0,    4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd15, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd15, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd15, 33'h2000, 4'h1, 4'h1, 4'h0, 16'd1));
        s.push_back(st(0, 0, 10'd15, 33'h2000, 4'h1, 4'h0, 4'h0, 16'd1));
        foreach (s[i]) begin
            exp_q.push_back(expect_of(s[i]));
            drive(s[i]);
            got = obs_a();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL onset step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_debounce();
        step_t s[$];
        obs_t got, e;
        s.push_back(st(1, 0, 10'd0,  33'h0,    4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd15, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd15, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd25, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd15, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 0, 10'd15, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd15, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd15, 33'h2000, 4'h1, 4'h1, 4'h0, 16'd1));
        foreach (s[i]) begin
            exp_q.push_back(expect_of(s[i]));
            drive(s[i]);
            got = obs_a();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL debounce step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_release();
        step_t s[$];
        obs_t got, e;
        for (int k = 0; k < 4; k++) s.push_back(st(0, 1, 10'd25, 33'h2000, 4'h1, 4'h0, 4'h0, 16'd1));
        s.push_back(st(0, 1, 10'd12, 33'h1500, 4'h1, 4'h0, 4'h0, 16'd1));
        for (int k = 0; k < 4; k++) s.push_back(st(0, 1, 10'd25, 33'h2000, 4'h1, 4'h0, 4'h0, 16'd1));
        s.push_back(st(0, 1, 10'd25, 33'h2000, 4'h0, 4'h0, 4'h1, 16'd1));
        s.push_back(st(0, 0, 10'd25, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd1));
        foreach (s[i]) begin
            exp_q.push_back(expect_of(s[i]));
            drive(s[i]);
            got = obs_a();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL release step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_boundaries();
        step_t s[$];
        obs_t got, e;
        lo[3] = 10'd70;
        hi[3] = 10'd60;
        s.push_back(st(1, 0, 10'd0,  33'h0,         4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd60, 33'h1FFFFFFFF, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd65, 33'h1FFFFFFFF, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd70, 33'h1FFFFFFFF, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd10, 33'h1000,      4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd20, 33'h1000,      4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd10, 33'h1000,      4'h1, 4'h1, 4'h0, 16'd1));
        s.push_back(st(0, 1, 10'd15, 33'h0FFF,      4'h1, 4'h0, 4'h0, 16'd1));
        s.push_back(st(0, 1, 10'd21, 33'h2000,      4'h1, 4'h0, 4'h0, 16'd1));
        foreach (s[i]) begin
            exp_q.push_back(expect_of(s[i]));
            drive(s[i]);
            got = obs_a();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL boundary step %0d: got %h expected %h", i, got, e);
            end
        end
        lo[3] = 10'd60;
        hi[3] = 10'd70;
    endtask

    task automatic test_clear_arming();
        step_t s[$];
        obs_t got, e;
        s.push_back(st(1, 0, 10'd0,  33'h0,    4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd65, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd65, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(1, 1, 10'd65, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd65, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd65, 33'h2000, 4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd65, 33'h2000, 4'h8, 4'h8, 4'h0, 16'd1));
        foreach (s[i]) begin
            exp_q.push_back(expect_of(s[i]));
            drive(s[i]);
            got = obs_a();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL clear_arming step %0d: got %h expected %h", i, got, e);
            end
            if (i == 2 || i == 3) begin
                vectors++;
                if (st_a[7:6] !== ((i == 2) ? 2'(ARMING) : 2'(IDLE))) begin
                    miscompares++;
                    $display("FAIL clear_arming_state step %0d: got %0d", i, st_a[7:6]);
                end
            end
        end
    endtask

    task automatic test_back_to_back_multi();
        step_t s[$];
        obs_t got, e;
        s.push_back(st(1, 0, 10'd0,   33'h0,    4'h0, 4'h0, 4'h0, 16'd0));
        s.push_back(st(0, 1, 10'd37,  33'h1000, 4'h6, 4'h6, 4'h0, 16'd2));
        s.push_back(st(0, 0, 10'd37,  33'h1000, 4'h6, 4'h0, 4'h0, 16'd2));
        s.push_back(st(0, 1, 10'd100, 33'h1000, 4'h0, 4'h0, 4'h6, 16'd2));
        s.push_back(st(0, 1, 10'd37,  33'h1000, 4'h6, 4'h6, 4'h0, 16'd3));
        s.push_back(st(0, 1, 10'd100, 33'h1000, 4'h0, 4'h0, 4'h6, 16'd3));
        s.push_back(st(0, 1, 10'd15,  33'h2000, 4'h1, 4'h1, 4'h0, 16'd3));
        s.push_back(st(0, 1, 10'd35,  33'h0200, 4'h6, 4'h6, 4'h1, 16'd3));
        foreach (s[i]) begin
            exp_q.push_back(expect_of(s[i]));
            drive(s[i]);
            got = obs_b();
            e = exp_q.pop_front();
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL multi_sat step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    initial begin
        lo[0] = 10'd10; hi[0] = 10'd20; th[0] = 33'h1000;
        lo[1] = 10'd30; hi[1] = 10'd40; th[1] = 33'h0100;
        lo[2] = 10'd35; hi[2] = 10'd50; th[2] = 33'h0200;
        lo[3] = 10'd60; hi[3] = 10'd70; th[3] = 33'h1000;
        @(posedge clk);
        #1;
        test_reset();
        test_onset();
        test_debounce();
        test_release();
        test_boundaries();
        test_clear_arming();
        test_back_to_back_multi();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tone_event_detector.md
# tone_event_detector

Per-frame tone event detector and parametrised successor to the single-threshold whistle `fire` flag. It sits after `fft_pitch_detect` in the `adc_clk` (FFT) domain and consumes one peak-bin/peak-magnitude pair per FFT frame. It tracks `N_BANDS` independent, runtime-configurable frequency bands, each with its own magnitude threshold. Each band has onset debouncing (`ON_FRAMES`) and release hysteresis (`OFF_FRAMES`), and the block produces level, pulse and count outputs for downstream actuation and display.

## Interface
Parameters:
- `BIN_W`, 10: width of FFT bin index; equals `$clog2(NSamples)`.
- `MAG_W`, 33: width of peak magnitude.
- `N_BANDS`, 4: number of tracked bands; legal range 1..16.
- `ON_FRAMES`, 3: consecutive hit frames required to activate; must be ≥1.
- `OFF_FRAMES`, 5: consecutive miss frames required to release; must be ≥1.
- `CNT_W`, 16: width of the saturating onset counter.

Ports:
- `clk`, in, 1: FFT-domain clock.
- `reset`, in, 1: synchronous, active-high.
- `clear`, in, 1: synchronous soft clear; same effect as `reset` on state and outputs.
- `frame_valid`, in, 1: one-cycle strobe; qualifies `peak_bin` and `peak_mag`.
- `peak_bin`, in, `BIN_W`: peak bin index of the frame.
- `peak_mag`, in, `MAG_W`: peak magnitude of the frame (unsigned).
- `band_lo`, in, `N_BANDS*BIN_W`: inclusive lower bin bound per band; band i occupies slice i.
- `band_hi`, in, `N_BANDS*BIN_W`: inclusive upper bin bound per band.
- `band_thresh`, in, `N_BANDS*MAG_W`: per-band magnitude threshold.
- `band_active`, out, `N_BANDS`: band is in ACTIVE or RELEASING.
- `fire`, out, 1: OR of `band_active`.
- `onset_pulse`, out, `N_BANDS`: one-cycle pulse when a band enters ACTIVE from IDLE or ARMING.
- `offset_pulse`, out, `N_BANDS`: one-cycle pulse when a band enters IDLE from ACTIVE or RELEASING.
- `event_band`, out, `$clog2(N_BANDS)` (minimum 1): index of the lowest-numbered active band; 0 when none is active.
- `event_count`, out, `CNT_W`: total onsets across all bands, saturating.

## Operation
- Hit for band i: `frame_valid` is high, `band_lo[i] ≤ peak_bin ≤ band_hi[i]`, and `peak_mag ≥ band_thresh[i]` (unsigned comparison).
- Miss for band i: `frame_valid` is high and the hit condition is false.
- Cycles without `frame_valid` are neither hit nor miss; state holds.
- Overlapping bands evaluate independently, so one frame may hit several bands.
- A band with `lo > hi` never hits.
- Config ports are sampled on each `frame_valid` only; they may change between frames.
- Per-band FSM, with `on_cnt` and `off_cnt` each `$clog2(max+1)` bits:
  - IDLE, on hit: go to ACTIVE if `ON_FRAMES==1`, else go to ARMING with `on_cnt=1`. On miss: stay.
  - ARMING, on hit: `on_cnt+1`; go to ACTIVE when `on_cnt+1==ON_FRAMES`. On miss: go to IDLE with `on_cnt=0`.
  - ACTIVE, on hit: stay. On miss: go to IDLE if `OFF_FRAMES==1`, else go to RELEASING with `off_cnt=1`.
  - RELEASING, on hit: go to ACTIVE with `off_cnt=0`; no onset pulse. On miss: `off_cnt+1`; go to IDLE when it equals `OFF_FRAMES`.
- `event_count` adds the popcount of that cycle's onsets, saturating at `2^CNT_W-1`. Simultaneous onsets in several bands all count.
- `reset` or `clear` puts all bands in IDLE, zeroes all counters, and drives every output to 0. It has priority over a coincident `frame_valid`, which is dropped. Asserting it mid-ARMING or mid-RELEASING discards partial counts.

## Timing
- State and outputs register on the `clk` edge that samples `frame_valid`. Outputs are valid in the following cycle (latency 1).
- `onset_pulse` and `offset_pulse` are high for exactly one cycle per transition, aligned with the `band_active` change.
- `fire` and `event_band` are registered from the same next-state values as `band_active`. They are never a cycle behind.
- Back-to-back `frame_valid` (every cycle) is supported at full rate.
- Reset value of all outputs is 0.

## Structure
- Package `tone_event_pkg`: enum `band_state_t` {IDLE, ARMING, ACTIVE, RELEASING}, and `localparam` helper functions for counter widths.
- Sub-module `band_tracker`: one instance per band via generate. It contains the compare logic, FSM and counters, and outputs `active`, `onset` and `offset`.
- Top-level logic: OR reduction, priority encoder for `event_band`, and the saturating popcount accumulator.

## Test plan
- Band 0 = [10,20], thresh `0x1000`, `ON_FRAMES=3`. Three frames at bin 15, mag `0x2000` → `onset_pulse[0]` and `fire` go high one cycle after the third `frame_valid`; `event_count=1`.
- Same band, two hits then one miss then two hits → no onset; band stays inactive. A third consecutive hit then activates it.
- Active band 0, `OFF_FRAMES=5`: four misses, then a hit, then five misses → stays active through the interruption. `offset_pulse[0]` fires only after the fifth consecutive miss.
- Bands 1 = [30,40] and 2 = [35,50], one frame at bin 37 above both thresholds, `ON_FRAMES=1` → both onset pulses in the same cycle; `event_count` increments by 2; `event_band=1`.
- Mag exactly equal to the threshold → counts as a hit. Bin equal to `band_lo` or `band_hi` → counts as a hit. A band configured with `lo > hi` → never activates.
- `clear` asserted while band 3 is in ARMING with `on_cnt=2`, coincident with a hit frame → all outputs 0 next cycle. A subsequent run needs a full `ON_FRAMES` hits. Check `event_count` saturation by forcing `CNT_W=2` and issuing 5 onsets, which must give 3.
